// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between multicycle controller and datapath
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, alucontrol, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore sequencing FSM for the multicycle MIPS datapath
// Outputs decode the state; FETCH enables wait on mem_ready and PCEn folds in the ALU zero flag.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  aluop_t     w_aluop;
  logic       w_iord, w_memwrite, w_irwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_alusrca, w_pcwrite, w_branch, w_bad_op, w_bad_funct;
  logic [1:0] w_alusrcb, w_pcsrc;
  logic [2:0] w_aluctl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = S_FETCH;
    w_aluop    = ALUOP_ADD;
    w_iord     = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_bad_op   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        if (bus.mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        w_alusrcb = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default: begin
            w_bad_op = 1'b1;
            w_next   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      // MemWrite stays asserted for every held cycle until memory accepts it
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_next     = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_FUNCT;
        w_next    = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_aluop   = ALUOP_SUB;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
      end
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JEX: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Unknown funct falls back to add so the R-type still completes
  always_comb begin
    w_aluctl    = 3'b010;
    w_bad_funct = 1'b0;
    case (w_aluop)
      ALUOP_SUB: w_aluctl = 3'b110;
      ALUOP_FUNCT: begin
        case (bus.funct)
          6'b100000: w_aluctl = 3'b010;
          6'b100010: w_aluctl = 3'b110;
          6'b100100: w_aluctl = 3'b000;
          6'b100101: w_aluctl = 3'b001;
          6'b101010: w_aluctl = 3'b111;
          default:   w_bad_funct = 1'b1;
        endcase
      end
      default: w_aluctl = 3'b010;
    endcase
  end

  // Write enables are masked by reset so an asserted reset can never commit anything
  assign bus.IorD       = w_iord;
  assign bus.MemWrite   = w_memwrite & reset_n;
  assign bus.IRWrite    = w_irwrite & reset_n;
  assign bus.RegDst     = w_regdst;
  assign bus.MemToReg   = w_memtoreg;
  assign bus.RegWrite   = w_regwrite & reset_n;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.PCSrc      = w_pcsrc;
  assign bus.PCEn       = (w_pcwrite | (w_branch & bus.zero)) & reset_n;
  assign bus.alucontrol = w_aluctl;
  assign bus.illegal    = w_bad_op | w_bad_funct;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed and randomized checks of multicycle_controller against a per-instruction plan model
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset_n;
  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model: each fetched instruction expands into the list of states it must visit
  int exp_st = 0;
  int plan[$];
  int ins_cpi = 0;

  logic [3:0] t_st[16];
  logic       t_mw[16], t_rw[16], t_m2r[16], t_rd[16], t_pcen[16], t_ill[16];
  logic [1:0] t_pcsrc[16];
  logic [2:0] t_alu[16];
  logic [3:0] st_after;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [3:0] fn_map(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b1010;
    endcase
  endfunction

  function automatic logic op_known(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // {IorD,MemWrite,IRWrite,RegDst,MemToReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,PCEn,alucontrol,illegal}
  function automatic logic [15:0] exp_vec(input int s, input logic [5:0] op, input logic [5:0] fn,
                                          input logic z, input logic mr, input logic rn);
    logic iord, mw, irw, rd, m2r, rw, sa, pcen, ill;
    logic [1:0] sb, ps;
    logic [2:0] aluc;
    iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; pcen = 0; ill = 0;
    sb = 2'b00; ps = 2'b00; aluc = 3'b010;
    case (s)
      0:  begin sb = 2'b01; irw = mr; pcen = mr; end
      1:  begin sb = 2'b11; ill = !op_known(op); end
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; {ill, aluc} = fn_map(fn); end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; aluc = 3'b110; ps = 2'b01; pcen = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pcen = 1; end
      default: ;
    endcase
    if (!rn) begin mw = 0; irw = 0; rw = 0; pcen = 0; end
    return {iord, mw, irw, rd, m2r, rw, sa, sb, ps, pcen, aluc, ill};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_st = 0;
      plan.delete();
    end else if ((exp_st == 0 || exp_st == 3 || exp_st == 5) && !bus.mem_ready) begin
      exp_st = exp_st;
    end else if (exp_st == 0) begin
      case (bus.opcode)
        6'b100011: begin plan = '{1, 2, 3, 4}; ins_cpi = 5; end
        6'b101011: begin plan = '{1, 2, 5};    ins_cpi = 4; end
        6'b000000: begin plan = '{1, 6, 7};    ins_cpi = 4; end
        6'b000100: begin plan = '{1, 8};       ins_cpi = 3; end
        6'b001000: begin plan = '{1, 9, 10};   ins_cpi = 4; end
        6'b000010: begin plan = '{1, 11};      ins_cpi = 3; end
        default:   begin plan = '{1};          ins_cpi = 2; end
      endcase
      exp_st = plan.pop_front();
    end else if (plan.size() == 0) begin
      exp_st = 0;
    end else begin
      exp_st = plan.pop_front();
    end
  end

  int prev_st = 15;
  bit have_start = 1'b0;
  int ncyc = 0;
  int nstall = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      logic [15:0] e, g;
      e = exp_vec(exp_st, bus.opcode, bus.funct, bus.zero, bus.mem_ready, reset_n);
      g = {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemToReg, bus.RegWrite, bus.ALUSrcA,
           bus.ALUSrcB, bus.PCSrc, bus.PCEn, bus.alucontrol, bus.illegal};
      n_cmp++;
      if (g !== e || bus.state !== 4'(exp_st)) begin
        n_bad++;
        $display("FAIL model t=%0t: state %0d outs %h, want state %0d outs %h", $time, bus.state, g, exp_st, e);
      end
      if (!reset_n) begin
        have_start = 1'b0;
        prev_st = 15;
      end else begin
        if (bus.state == 4'd0 && prev_st != 0) begin
          if (have_start) begin
            n_cmp++;
            if (ncyc != ins_cpi + nstall) begin
              n_bad++;
              $display("FAIL cpi t=%0t: got %0d cycles, want %0d", $time, ncyc, ins_cpi + nstall);
            end
          end
          have_start = 1'b1;
          ncyc = 0;
          nstall = 0;
        end
        ncyc++;
        if ((bus.state == 4'd0 || bus.state == 4'd3 || bus.state == 4'd5) && !bus.mem_ready) nstall++;
        prev_st = int'(bus.state);
      end
    end
  end

  // Called at posedge+1; each iteration is one clock with mem_ready taken from mr[i]
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int n, input logic [15:0] mr);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = mr[i];
      @(negedge clk);
      t_st[i] = bus.state;   t_mw[i] = bus.MemWrite;  t_rw[i] = bus.RegWrite;
      t_m2r[i] = bus.MemToReg; t_rd[i] = bus.RegDst; t_pcen[i] = bus.PCEn;
      t_pcsrc[i] = bus.PCSrc; t_alu[i] = bus.alucontrol; t_ill[i] = bus.illegal;
      @(posedge clk);
      #1;
    end
    st_after = bus.state;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.opcode = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    chk_on = 1'b1;
    #12;
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_enables", 32'({bus.IRWrite, bus.PCEn, bus.MemWrite, bus.RegWrite}), 32'h0);
    chk("rst_alusrcb", 32'(bus.ALUSrcB), 32'h1);
    chk("rst_aluctl", 32'(bus.alucontrol), 32'h2);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run(6'b100011, 6'd0, 1'b0, 5, 16'h001F);
    chk("lw_seq", 32'({t_st[0], t_st[1], t_st[2], t_st[3], t_st[4]}), 32'h01234);
    chk("lw_wb", 32'({t_m2r[4], t_rw[4]}), 32'h3);
    chk("lw_after", 32'(st_after), 32'h0);

    run(6'b100011, 6'd0, 1'b0, 7, 16'h0067);
    chk("lw_stall_seq", 32'({t_st[0], t_st[1], t_st[2], t_st[3], t_st[4], t_st[5], t_st[6]}), 32'h0123334);
    chk("lw_stall_rw", 32'({t_rw[0], t_rw[1], t_rw[2], t_rw[3], t_rw[4], t_rw[5], t_rw[6]}), 32'h01);
    chk("lw_stall_after", 32'(st_after), 32'h0);

    run(6'b101011, 6'd0, 1'b0, 7, 16'h0047);
    chk("sw_seq", 32'({t_st[0], t_st[1], t_st[2], t_st[3], t_st[4], t_st[5], t_st[6]}), 32'h0125555);
    chk("sw_memwrite", 32'({t_mw[0], t_mw[1], t_mw[2], t_mw[3], t_mw[4], t_mw[5], t_mw[6]}), 32'h0F);
    chk("sw_after", 32'(st_after), 32'h0);

    run(6'b000000, 6'b101010, 1'b0, 4, 16'h000F);
    chk("slt_seq", 32'({t_st[0], t_st[1], t_st[2], t_st[3]}), 32'h0167);
    chk("slt_alu", 32'({t_ill[2], t_alu[2]}), 32'h7);
    chk("slt_wb", 32'({t_rd[3], t_rw[3]}), 32'h3);

    run(6'b000000, 6'b111111, 1'b0, 4, 16'h000F);
    chk("badfn_ex", 32'({t_ill[2], t_alu[2]}), 32'hA);
    chk("badfn_wb", 32'({t_st[3], t_rw[3]}), 32'hF);

    run(6'b000100, 6'd0, 1'b1, 3, 16'h0007);
    chk("beq_taken", 32'({t_st[2], t_pcen[2], t_pcsrc[2]}), 32'h45);
    run(6'b000100, 6'd0, 1'b0, 3, 16'h0007);
    chk("beq_not_taken", 32'({t_st[2], t_pcen[2], t_pcsrc[2]}), 32'h41);

    run(6'b000010, 6'd0, 1'b0, 3, 16'h0007);
    chk("j_seq", 32'({t_st[0], t_st[1], t_st[2]}), 32'h01B);
    chk("j_pc", 32'({t_pcen[2], t_pcsrc[2]}), 32'h6);
    chk("j_after", 32'(st_after), 32'h0);

    run(6'b111111, 6'd0, 1'b0, 2, 16'h0003);
    chk("badop", 32'({t_st[1], t_ill[1]}), 32'h3);
    chk("badop_after", 32'(st_after), 32'h0);

    run(6'b101011, 6'd0, 1'b0, 4, 16'h0007);
    chk("rst_mid_pre", 32'({st_after, bus.MemWrite}), 32'hB);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_async", 32'({bus.state, bus.MemWrite}), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      if (exp_st == 0) begin
        case ($urandom_range(0, 7))
          0: bus.opcode = 6'b100011;
          1: bus.opcode = 6'b101011;
          2, 3: bus.opcode = 6'b000000;
          4: bus.opcode = 6'b000100;
          5: bus.opcode = 6'b001000;
          6: bus.opcode = 6'b000010;
          default: bus.opcode = 6'($urandom_range(0, 63));
        endcase
        case ($urandom_range(0, 5))
          0: bus.funct = 6'b100000;
          1: bus.funct = 6'b100010;
          2: bus.funct = 6'b100100;
          3: bus.funct = 6'b100101;
          4: bus.funct = 6'b101010;
          default: bus.funct = 6'($urandom_range(0, 63));
        endcase
      end
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.zero = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
